// File: rtl/if_stage_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_skid_reg_pkg
//
// Shared definitions for the fetch-to-decode skid register:
//   - default payload and counter widths
//   - the NOP instruction (ARM AL-condition AND r0,r0,r0) driven on an
//     empty output or after flush/reset
//   - state encoding built from the two entry valid bits
//   - payload register update selectors used between the FSM and datapath
// -----------------------------------------------------------------------------
package if_stage_skid_reg_pkg;

    localparam int PC_W_DEFAULT    = 32;
    localparam int INSTR_W_DEFAULT = 32;
    localparam int CNT_W_DEFAULT   = 16;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE000_0000;

    // Bit 0 is the main-entry valid bit, bit 1 the skid-entry valid bit, so
    // the state register is the pair of valid flops itself. 2'b10 (skid
    // valid without main valid) is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    // How the main register is updated on the next edge.
    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'b00,
        MAIN_LOAD_IN   = 2'b01,
        MAIN_LOAD_SKID = 2'b10,
        MAIN_CLEAR     = 2'b11
    } main_sel_t;

    // How the skid register is updated on the next edge.
    typedef enum logic [1:0] {
        SKID_HOLD    = 2'b00,
        SKID_LOAD_IN = 2'b01,
        SKID_CLEAR   = 2'b10
    } skid_sel_t;

endpackage

// File: rtl/if_stage_skid_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter used for the stall and flush performance counters.
// Counts one per cycle while inc is high and sticks at all-ones. Only rst
// clears it.
//
// Ports:
//   clk  in   1  clock, rising edge
//   rst  in   1  reset, asynchronous, active-high
//   inc  in   1  count this cycle
//   cnt  out  W  current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of process order.
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/if_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// if_stage_skid_reg
//
// Fetch-to-decode pipeline register with a valid/ready handshake and a
// 2-entry skid buffer. in_ready depends only on flops, so a decode stall
// never forms a combinational path back into fetch. A flush empties both
// entries and drops the incoming beat. Stall and flush cycles are counted
// in saturating performance counters.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        reset, asynchronous, active-high
//   flush      in   1        kill held entries and the incoming beat
//   in_valid   in   1        fetch presents a beat
//   in_ready   out  1        stage can accept a beat (from flops only)
//   pc_in      in   PC_W     PC of the fetched instruction
//   instr_in   in   INSTR_W  fetched instruction
//   out_valid  out  1        main entry holds a valid beat
//   out_ready  in   1        decode accepts the beat (low = freeze)
//   pc_out     out  PC_W     main-entry PC, 0 when invalid
//   instr_out  out  INSTR_W  main-entry instruction, NOP_INSTR when invalid
//   stall_cnt  out  CNT_W    cycles with out_valid & ~out_ready, saturating
//   flush_cnt  out  CNT_W    flush cycles that killed something, saturating
// -----------------------------------------------------------------------------
module if_stage_skid_reg
    import if_stage_skid_reg_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEFAULT,
    parameter int                 INSTR_W   = INSTR_W_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
    parameter int                 CNT_W     = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    state_t    state_q;
    state_t    state_d;
    main_sel_t main_sel;
    skid_sel_t skid_sel;

    logic [PC_W-1:0]    main_pc_q;
    logic [INSTR_W-1:0] main_instr_q;
    logic [PC_W-1:0]    skid_pc_q;
    logic [INSTR_W-1:0] skid_instr_q;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;
    logic stall_inc;
    logic flush_inc;

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and payload-update selection
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        main_sel = MAIN_HOLD;
        skid_sel = SKID_HOLD;

        if (flush) begin
            // Any out_fire this cycle has already been taken by decode; the
            // rest, including the incoming beat, is discarded.
            state_d  = EMPTY;
            main_sel = MAIN_CLEAR;
            skid_sel = SKID_CLEAR;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d  = ONE;
                        main_sel = MAIN_LOAD_IN;
                    end
                end

                ONE: begin
                    if (in_fire && out_fire) begin
                        main_sel = MAIN_LOAD_IN;
                    end else if (in_fire) begin
                        state_d  = TWO;
                        skid_sel = SKID_LOAD_IN;
                    end else if (out_fire) begin
                        state_d  = EMPTY;
                        main_sel = MAIN_CLEAR;
                    end
                end

                TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_d  = ONE;
                        main_sel = MAIN_LOAD_SKID;
                        skid_sel = SKID_CLEAR;
                    end
                end

                default: begin
                    state_d  = EMPTY;
                    main_sel = MAIN_CLEAR;
                    skid_sel = SKID_CLEAR;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Handshake outputs, decoded from the state flops only
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q != TWO);
        out_valid = main_valid;
    end

    // -------------------------------------------------------------------------
    // Payload registers. An invalid entry always carries pc=0 and NOP_INSTR,
    // so the outputs come straight from the main register without a mux.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the payload is reset as well as the valid bits, because the
            // outputs must show pc=0 / NOP_INSTR and never X straight after reset.
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
        end else begin
            unique case (main_sel)
                MAIN_LOAD_IN: begin
                    main_pc_q    <= pc_in;
                    main_instr_q <= instr_in;
                end
                MAIN_LOAD_SKID: begin
                    main_pc_q    <= skid_pc_q;
                    main_instr_q <= skid_instr_q;
                end
                MAIN_CLEAR: begin
                    main_pc_q    <= '0;
                    main_instr_q <= NOP_INSTR;
                end
                default: begin
                    main_pc_q    <= main_pc_q;
                    main_instr_q <= main_instr_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            unique case (skid_sel)
                SKID_LOAD_IN: begin
                    skid_pc_q    <= pc_in;
                    skid_instr_q <= instr_in;
                end
                SKID_CLEAR: begin
                    skid_pc_q    <= '0;
                    skid_instr_q <= NOP_INSTR;
                end
                default: begin
                    skid_pc_q    <= skid_pc_q;
                    skid_instr_q <= skid_instr_q;
                end
            endcase
        end
    end

    assign pc_out    = main_pc_q;
    assign instr_out = main_instr_q;

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    assign stall_inc = out_valid & ~out_ready;

    // A flush counts only if it destroyed something: a skid entry, a main
    // entry that decode did not take this cycle, or an accepted input beat.
    assign flush_inc = flush & (skid_valid | (main_valid & ~out_ready) | in_fire);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_if_stage_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_if_stage_skid_reg
//
// Directed bench for if_stage_skid_reg with 4-bit counters so saturation is
// reachable quickly. Inputs are driven 1 ns after the rising edge and
// outputs are sampled at the same point, i.e. they show the state the edge
// just produced.
// -----------------------------------------------------------------------------
module tb_if_stage_skid_reg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;
    localparam logic [31:0] NOP = 32'hE000_0000;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] instr_out;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    if_stage_skid_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_out    (pc_out),
        .instr_out (instr_out),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_for(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        pc_in    = v ? pc : 32'h0;
        instr_in = v ? instr_for(pc) : 32'h0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0);

        // ---------------- reset state ----------------
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_pc_out",    64'(pc_out),    64'd0);
        check("rst_instr_out", 64'(instr_out), 64'(NOP));
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // ---------------- flush while empty ----------------
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty_valid", 64'(out_valid), 64'd0);
        check("flush_empty_cnt",   64'(flush_cnt), 64'd0);

        // ---------------- streaming ----------------
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(4 * i));
            tick();
            check($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("stream_pc_%0d", i),    64'(pc_out),    64'(4 * i));
            check($sformatf("stream_instr_%0d", i), 64'(instr_out), 64'(32'hA000_0000 | 32'(4 * i)));
            check($sformatf("stream_ready_%0d", i), 64'(in_ready),  64'd1);
        end
        drive(1'b0, 32'h0);
        tick();
        check("stream_drain_valid", 64'(out_valid), 64'd0);
        check("stream_drain_pc",    64'(pc_out),    64'd0);
        check("stream_drain_instr", 64'(instr_out), 64'(NOP));
        check("stream_stall_cnt",   64'(stall_cnt), 64'd0);

        // ---------------- stall / skid ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'd4);
        tick();                              // ONE, main=4
        check("skid_one_pc", 64'(pc_out), 64'd4);
        drive(1'b1, 32'd8);
        tick();                              // TWO, stall 1
        drive(1'b0, 32'h0);
        check("skid_two_ready", 64'(in_ready), 64'd0);
        check("skid_two_pc",    64'(pc_out),   64'd4);
        tick();                              // stall 2
        tick();                              // stall 3
        check("skid_stall_cnt3", 64'(stall_cnt), 64'd3);
        check("skid_hold_pc",    64'(pc_out),    64'd4);
        check("skid_hold_ready", 64'(in_ready),  64'd0);
        out_ready = 1'b1;
        tick();                              // pc 4 consumed, 8 moves up
        check("skid_drain_pc8",    64'(pc_out),    64'd8);
        check("skid_drain_instr8", 64'(instr_out), 64'(32'hA000_0008));
        check("skid_drain_valid",  64'(out_valid), 64'd1);
        check("skid_drain_ready",  64'(in_ready),  64'd1);
        tick();                              // pc 8 consumed
        check("skid_empty_valid", 64'(out_valid), 64'd0);
        check("skid_stall_final", 64'(stall_cnt), 64'd3);

        // ---------------- flush in TWO with an incoming beat ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'd20);
        tick();                              // ONE
        drive(1'b1, 32'd24);
        tick();                              // TWO, stall 4
        check("flush_two_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'd12);
        flush = 1'b1;
        tick();                              // EMPTY, stall 5, flush 1
        flush = 1'b0;
        drive(1'b0, 32'h0);
        check("flush_valid",     64'(out_valid), 64'd0);
        check("flush_instr",     64'(instr_out), 64'(NOP));
        check("flush_pc",        64'(pc_out),    64'd0);
        check("flush_ready",     64'(in_ready),  64'd1);
        check("flush_cnt1",      64'(flush_cnt), 64'd1);
        check("flush_stall_cnt", 64'(stall_cnt), 64'd5);
        out_ready = 1'b1;
        tick();
        check("flush_no_ghost_valid", 64'(out_valid), 64'd0);
        tick();
        check("flush_no_ghost_pc", 64'(pc_out), 64'd0);

        // ---------------- reset mid-stream with both entries full ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'd28);
        tick();                              // ONE
        drive(1'b1, 32'd32);
        tick();                              // TWO, stall 6
        drive(1'b0, 32'h0);
        check("pre_rst_ready", 64'(in_ready),  64'd0);
        check("pre_rst_stall", 64'(stall_cnt), 64'd6);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready),  64'd1);
        check("mid_rst_pc",    64'(pc_out),    64'd0);
        check("mid_rst_instr", 64'(instr_out), 64'(NOP));
        check("mid_rst_stall", 64'(stall_cnt), 64'd0);
        check("mid_rst_flush", 64'(flush_cnt), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'd36);
        tick();
        drive(1'b0, 32'h0);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_pc",    64'(pc_out),    64'd36);
        tick();
        check("post_rst_empty", 64'(out_valid), 64'd0);

        // ---------------- stall counter saturation ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'd40);
        tick();                              // ONE, counting starts next edge
        drive(1'b0, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_cnt14", 64'(stall_cnt), 64'd14);
            if (i == 15) check("sat_cnt15", 64'(stall_cnt), 64'd15);
        end
        check("sat_hold15",  64'(stall_cnt), 64'd15);
        check("sat_pc_held", 64'(pc_out),    64'd40);
        check("sat_valid",   64'(out_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
